// File: rtl/mmv_ram_addr_bus_tester.sv
// Walking-ones address-bus tester for a RAM behind a memory-mapped master port.
// Optional build macro MMV_RAM_AB_TESTER_STOP_ON_FAULT_EN ends the run on the first mismatch.
module mmv_ram_addr_bus_tester #(
  parameter int AWIDTH = 8,
  parameter int DWIDTH = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              start,
  output logic              ready,
  output logic              fault,
  output logic              done,
  output logic [AWIDTH-1:0] m_addr,
  output logic              m_wreq,
  output logic [DWIDTH-1:0] m_wdat,
  output logic              m_rreq,
  input  logic [DWIDTH-1:0] m_rdat,
  input  logic              m_rval,
  input  logic              m_busy,
  output logic [1:0]        dbg_state_o,
  output logic [2:0]        dbg_phase_o
);

  // Handshake: m_wreq/m_rreq act as valid, !m_busy as ready. A request and its
  // m_addr/m_wdat stay constant until a cycle with m_busy=0 accepts it; after an
  // accepted read nothing new is issued until m_rval returns the data.

  localparam int IW = $clog2(AWIDTH) + 1;
  localparam logic [IW-1:0] ONE      = IW'(1);
  localparam logic [IW-1:0] LAST_IDX = IW'(AWIDTH - 1);
  localparam logic [IW-1:0] AW_IDX   = IW'(AWIDTH);

  function automatic logic [DWIDTH-1:0] alt_pattern();
    logic [DWIDTH-1:0] p;
    for (int k = 0; k < DWIDTH; k++) p[k] = (((DWIDTH - 1 - k) % 2) == 0);
    return p;
  endfunction

  localparam logic [DWIDTH-1:0] PAT  = alt_pattern();
  localparam logic [DWIDTH-1:0] ANTI = ~PAT;

  function automatic logic [AWIDTH-1:0] one_hot(input logic [IW-1:0] k);
    return {{(AWIDTH-1){1'b0}}, 1'b1} << k;
  endfunction

  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_WAIT, ST_DONE} state_t;
  typedef enum logic [2:0] {
    PH_S1, PH_S1Z, PH_S2, PH_S3, PH_S4W, PH_S4R0, PH_S4RI, PH_S4P
  } phase_t;

  state_t state_q, state_d;
  phase_t phase_q, phase_d;
  logic [IW-1:0] i_q, i_d, j_q, j_d, nxt_i;
  logic fault_q;
  logic op_read, seq_last, op_done, mismatch, stop_now;
  logic [AWIDTH-1:0] op_addr;
  logic [DWIDTH-1:0] op_wdat;

  // Current operation decoded from the sequence position.
  always_comb begin
    op_read = 1'b0;
    op_addr = '0;
    op_wdat = PAT;
    case (phase_q)
      PH_S1:   op_addr = one_hot(i_q);
      PH_S1Z:  op_wdat = ANTI;
      PH_S2:   begin op_read = 1'b1; op_addr = one_hot(i_q); end
      PH_S3:   op_wdat = PAT;
      PH_S4W:  begin op_addr = one_hot(j_q); op_wdat = ANTI; end
      PH_S4R0: op_read = 1'b1;
      PH_S4RI: begin op_read = 1'b1; op_addr = one_hot(i_q); end
      PH_S4P:  op_addr = one_hot(j_q);
      default: op_addr = '0;
    endcase
  end

  // Sequence position after the current operation completes.
  always_comb begin
    phase_d  = phase_q;
    i_d      = i_q;
    j_d      = j_q;
    seq_last = 1'b0;
    nxt_i    = i_q + ONE;
    if (nxt_i == j_q) nxt_i = nxt_i + ONE;
    case (phase_q)
      PH_S1:   if (i_q == LAST_IDX) phase_d = PH_S1Z; else i_d = i_q + ONE;
      PH_S1Z:  begin phase_d = PH_S2; i_d = '0; end
      PH_S2:   if (i_q == LAST_IDX) phase_d = PH_S3; else i_d = i_q + ONE;
      PH_S3:   begin phase_d = PH_S4W; j_d = '0; end
      PH_S4W:  phase_d = PH_S4R0;
      PH_S4R0: begin phase_d = PH_S4RI; i_d = (j_q == '0) ? ONE : '0; end
      PH_S4RI: if (nxt_i >= AW_IDX) phase_d = PH_S4P; else i_d = nxt_i;
      PH_S4P: begin
        if (j_q == LAST_IDX) seq_last = 1'b1;
        else begin
          j_d     = j_q + ONE;
          phase_d = PH_S4W;
        end
      end
      default: phase_d = PH_S1;
    endcase
  end

  assign op_done  = ((state_q == ST_REQ) && !m_busy && !op_read) ||
                    ((state_q == ST_WAIT) && m_rval);
  assign mismatch = (state_q == ST_WAIT) && m_rval && (m_rdat != PAT);

`ifdef MMV_RAM_AB_TESTER_STOP_ON_FAULT_EN
  assign stop_now = mismatch;
`else
  assign stop_now = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (clear) state_d = ST_IDLE;
    else begin
      case (state_q)
        ST_IDLE: if (start) state_d = ST_REQ;
        ST_REQ: begin
          if (!m_busy) begin
            if (op_read)       state_d = ST_WAIT;
            else if (seq_last) state_d = ST_DONE;
            else               state_d = ST_REQ;
          end
        end
        ST_WAIT: if (m_rval) state_d = (seq_last || stop_now) ? ST_DONE : ST_REQ;
        ST_DONE: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Idle keeps the sequence parked at its first write so a start begins cleanly.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      phase_q <= PH_S1;
      i_q     <= '0;
      j_q     <= '0;
      fault_q <= 1'b0;
    end else begin
      fault_q <= mismatch && !clear;
      if (state_q == ST_IDLE) begin
        phase_q <= PH_S1;
        i_q     <= '0;
        j_q     <= '0;
      end else if (op_done) begin
        phase_q <= phase_d;
        i_q     <= i_d;
        j_q     <= j_d;
      end
    end
  end

  always_comb begin
    ready  = (state_q == ST_IDLE);
    done   = (state_q == ST_DONE);
    fault  = fault_q;
    m_wreq = 1'b0;
    m_rreq = 1'b0;
    m_addr = '0;
    m_wdat = '0;
    if (state_q == ST_REQ) begin
      m_wreq = !op_read;
      m_rreq = op_read;
      m_addr = op_addr;
      m_wdat = op_read ? '0 : op_wdat;
    end
  end

  assign dbg_state_o = state_q;
  assign dbg_phase_o = phase_q;

endmodule

// File: tb/tb_mmv_ram_addr_bus_tester.sv
// Bench for mmv_ram_addr_bus_tester: RAM slave with latency/stall/alias control and a
// spec-level expected operation list.
module tb_mmv_ram_addr_bus_tester;

  localparam logic [7:0] PAT  = 8'hAA;
  localparam logic [7:0] ANTI = 8'h55;

  logic       clk;
  logic       reset, clear, start;
  logic       ready, fault, done;
  logic [7:0] m_addr, m_wdat, m_rdat;
  logic       m_wreq, m_rreq, m_rval, m_busy;
  logic [1:0] dbg_state;
  logic [2:0] dbg_phase;

  mmv_ram_addr_bus_tester #(.AWIDTH(8), .DWIDTH(8)) dut (
    .clk(clk), .reset(reset), .clear(clear), .start(start),
    .ready(ready), .fault(fault), .done(done),
    .m_addr(m_addr), .m_wreq(m_wreq), .m_wdat(m_wdat), .m_rreq(m_rreq),
    .m_rdat(m_rdat), .m_rval(m_rval), .m_busy(m_busy),
    .dbg_state_o(dbg_state), .dbg_phase_o(dbg_phase)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_pass   = 0;
  logic [16:0] exp_q[$];          // {is_read, addr, data}
  logic [7:0]  mem [256];
  int   lat, stall_w, stall_r, sl_w, sl_r;
  bit   alias_en, mdl_active, pending, rd_void, seen_fault;
  bit   exp_fault_now, exp_done_now;
  int   rd_cnt_down, op_cnt, wr_cnt, rd_cnt, faults_cnt, done_cnt;
  logic [7:0] rd_data, rd_addr, first_fault_addr;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, expv);
  endtask

  function automatic logic [7:0] eff_addr(input logic [7:0] a);
    logic [7:0] e;
    e = a;
    if (alias_en) e[6] = a[5];
    return e;
  endfunction

  // Operation list straight from the test sequence description.
  task automatic build_exp();
    exp_q.delete();
    for (int i = 0; i < 8; i++) exp_q.push_back({1'b0, 8'(1 << i), PAT});
    exp_q.push_back({1'b0, 8'h00, ANTI});
    for (int i = 0; i < 8; i++) exp_q.push_back({1'b1, 8'(1 << i), PAT});
    exp_q.push_back({1'b0, 8'h00, PAT});
    for (int j = 0; j < 8; j++) begin
      exp_q.push_back({1'b0, 8'(1 << j), ANTI});
      exp_q.push_back({1'b1, 8'h00, PAT});
      for (int i = 0; i < 8; i++)
        if (i != j) exp_q.push_back({1'b1, 8'(1 << i), PAT});
      exp_q.push_back({1'b0, 8'(1 << j), PAT});
    end
  endtask

  // ---------------- slave + per-cycle compare ----------------
  initial begin : slave
    logic [16:0] e;
    logic [7:0]  ea;
    m_busy = 1'b0; m_rval = 1'b0; m_rdat = '0;
    pending = 0; exp_fault_now = 0; exp_done_now = 0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        pending = 0; m_rval = 1'b0; m_busy = 1'b0;
        exp_fault_now = 0; exp_done_now = 0;
      end else begin
        if (mdl_active) begin
          chk("fault_pulse", {31'd0, fault}, {31'd0, exp_fault_now});
          chk("done_pulse", {31'd0, done}, {31'd0, exp_done_now});
          chk("req_exclusive", {31'd0, m_wreq & m_rreq}, 32'd0);
        end
        if (fault) faults_cnt++;
        if (done)  done_cnt++;
        exp_fault_now = 0;
        exp_done_now  = 0;
        m_rval = 1'b0;
        if (pending) begin
          rd_cnt_down--;
          if (rd_cnt_down == 0) begin
            pending = 0;
            m_rval  = 1'b1;
            m_rdat  = rd_void ? ANTI : rd_data;
            exp_fault_now = mdl_active && !rd_void && (rd_data != PAT);
            if (exp_fault_now && !seen_fault) begin
              seen_fault = 1;
              first_fault_addr = rd_addr;
            end
          end
        end
        m_busy = 1'b0;
        if (mdl_active && (m_wreq || m_rreq)) begin
          if (exp_q.size() == 0) chk("unexpected_req", {24'd0, m_addr}, 32'hFFFF);
          else begin
            e = exp_q[0];
            chk("op_kind", {31'd0, m_rreq}, {31'd0, e[16]});
            chk("op_addr", {24'd0, m_addr}, {24'd0, e[15:8]});
            if (!e[16]) chk("op_wdat", {24'd0, m_wdat}, {24'd0, e[7:0]});
            if (op_cnt == stall_w && sl_w > 0) begin m_busy = 1'b1; sl_w--; end
            else if (op_cnt == stall_r && sl_r > 0) begin m_busy = 1'b1; sl_r--; end
            if (!m_busy) begin
              void'(exp_q.pop_front());
              op_cnt++;
              ea = eff_addr(m_addr);
              if (m_wreq) begin
                mem[ea] = m_wdat;
                wr_cnt++;
              end else begin
                rd_data = mem[ea];
                rd_addr = m_addr;
                rd_void = 0;
                pending = 1;
                rd_cnt_down = lat;
                rd_cnt++;
              end
              if (exp_q.size() == 0) exp_done_now = 1;
            end
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic start_run(input int l, input bit al, input int sw, input int sr);
    lat = l; alias_en = al; stall_w = sw; stall_r = sr; sl_w = 5; sl_r = 5;
    op_cnt = 0; wr_cnt = 0; rd_cnt = 0; faults_cnt = 0; done_cnt = 0; seen_fault = 0;
    first_fault_addr = '0;
    for (int a = 0; a < 256; a++) mem[a] = '0;
    build_exp();
    @(negedge clk); #1;
    start = 1'b1;
    @(negedge clk); #1;
    start = 1'b0;
  endtask

  task automatic finish_run(input string nm, input bit repulse, input int exp_faults);
    for (int c = 0; c < 3000 && done_cnt == 0; c++) begin
      @(negedge clk); #1;
      start = (repulse && c == 100);
    end
    start = 1'b0;
    chk({nm, "_done_seen"}, {31'd0, done_cnt > 0}, 32'd1);
    @(negedge clk); #1;
    chk({nm, "_ready_after"}, {31'd0, ready}, 32'd1);
    repeat (3) @(negedge clk);
    #1;
    chk({nm, "_done_cnt"}, done_cnt, 32'd1);
    chk({nm, "_writes"}, wr_cnt, 32'd26);
    chk({nm, "_reads"}, rd_cnt, 32'd72);
    chk({nm, "_faults"}, faults_cnt, exp_faults);
    chk({nm, "_ops_left"}, exp_q.size(), 32'd0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin : main
    bit found;
    reset = 1'b0; clear = 1'b0; start = 1'b0; mdl_active = 0;
    lat = 1; alias_en = 0; stall_w = -1; stall_r = -1; sl_w = 0; sl_r = 0;
    #12;
    chk("rst_ready", {31'd0, ready}, 32'd1);
    chk("rst_fault", {31'd0, fault}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_wreq", {31'd0, m_wreq}, 32'd0);
    chk("rst_rreq", {31'd0, m_rreq}, 32'd0);
    chk("rst_addr", {24'd0, m_addr}, 32'd0);
    chk("rst_wdat", {24'd0, m_wdat}, 32'd0);
    @(negedge clk); #1;
    reset = 1'b1; mdl_active = 1;

    build_exp();
    chk("model_ops", exp_q.size(), 32'd98);
    chk("model_first", {15'd0, exp_q[0]}, {15'd0, 1'b0, 8'h01, 8'hAA});

    // Healthy, latency 16, start re-pulsed mid-run.
    start_run(16, 0, -1, -1);
    finish_run("healthy_l16", 1, 0);

    // Latency 1 with 5-cycle stalls on a write (op 3) and a read (op 12).
    start_run(1, 0, 3, 12);
    finish_run("stall_l1", 0, 0);

    // Address bit 6 aliased to bit 5: S2 read of 0x40 and S4 j=6 read of 0 fail.
    start_run(4, 1, -1, -1);
    finish_run("alias", 0, 2);
    chk("alias_first_addr", {24'd0, first_fault_addr}, 32'h40);

    // Clear while a read is outstanding in S4.
    start_run(16, 0, -1, -1);
    found = 0;
    for (int c = 0; c < 3000 && !found; c++) begin
      @(negedge clk); #1;
      if (op_cnt >= 50 && pending && rd_cnt_down > 3) found = 1;
    end
    chk("clear_reached_s4", {31'd0, found}, 32'd1);
    clear = 1'b1; rd_void = 1; exp_q.delete();
    @(negedge clk); #1;
    clear = 1'b0;
    chk("clear_ready", {31'd0, ready}, 32'd1);
    chk("clear_no_req", {30'd0, m_wreq, m_rreq}, 32'd0);
    repeat (25) @(negedge clk);
    #1;
    chk("clear_no_done", done_cnt, 32'd0);
    chk("clear_no_fault", faults_cnt, 32'd0);
    start_run(2, 0, -1, -1);
    finish_run("rerun_l2", 0, 0);

    // Asynchronous reset in the middle of a run.
    start_run(16, 0, -1, -1);
    for (int c = 0; c < 3000 && op_cnt < 30; c++) begin
      @(negedge clk); #1;
    end
    #2;
    reset = 1'b0; mdl_active = 0;
    #1;
    chk("areset_ready", {31'd0, ready}, 32'd1);
    chk("areset_reqs", {30'd0, m_wreq, m_rreq}, 32'd0);
    chk("areset_addr", {24'd0, m_addr}, 32'd0);
    chk("areset_pulses", {30'd0, fault, done}, 32'd0);
    @(negedge clk); #1;
    reset = 1'b1; mdl_active = 1;
    @(negedge clk); #1;
    chk("areset_idle_after", {31'd0, ready}, 32'd1);
    start_run(3, 0, -1, -1);
    finish_run("after_reset_l3", 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mmv_ram_addr_bus_tester.md
Name: mmv_ram_addr_bus_tester

Overview:
- Self-contained address-bus tester for RAM behind a MemoryMapped master port with variable read latency.
- Runs a walking-ones address test that detects stuck-high, stuck-low and shorted/aliased address lines.
- Reports each mismatch with a one-cycle fault pulse and the end of the run with a one-cycle done pulse.
- Sits between a control/CSR block and a memory-controller slave port.

Parameters:
AWIDTH, 8, address width (>=2).
DWIDTH, 8, data width (>=2).

Ports:
clk  in  1  clock; all logic on rising edge.
reset  in  1  asynchronous, active-low reset (asserted 0); port keeps the codebase name reset.
clear  in  1  synchronous abort: returns to IDLE next cycle, no done pulse.
start  in  1  start test; sampled only while ready=1.
ready  out  1  high in IDLE.
fault  out  1  one-cycle pulse per read-data mismatch.
done  out  1  one-cycle pulse when the test completes.
m_addr  out  AWIDTH  request address.
m_wreq  out  1  write request.
m_wdat  out  DWIDTH  write data.
m_rreq  out  1  read request.
m_rdat  in  DWIDTH  read data.
m_rval  in  1  read data valid (latency >=1, arbitrary).
m_busy  in  1  slave stall; a request is accepted only on a cycle with m_busy=0.

Behaviour:
- Reset (reset=0): state IDLE; ready=1; fault, done, m_wreq, m_rreq=0; m_addr, m_wdat=0.
- Patterns:
  - PAT: alternating bits with MSB=1 (DWIDTH=8 gives 0xAA).
  - ANTI = ~PAT (0x55).
- A_i = 1<<i, for i = 0..AWIDTH-1.
- Handshake:
  - Request signals are held stable until accepted on a cycle with m_busy=0.
  - Only one operation is outstanding at a time.
  - After an accepted read, the tester issues no request until m_rval=1, then compares m_rdat with the expected value.
  - A mismatch pulses fault on the cycle after m_rval.
  - m_wreq and m_rreq are never high together.
- Sequence:
  - S1: write PAT to A_0..A_(AWIDTH-1) in ascending order, then write ANTI to address 0.
  - S2 (stuck-high): read A_0..A_(AWIDTH-1), expect PAT each.
  - S3: write PAT to address 0.
  - S4 (stuck-low/short), for j = 0..AWIDTH-1 in order:
    - write ANTI to A_j;
    - read address 0, expect PAT;
    - read A_i for every i != j in ascending order, expect PAT;
    - write PAT to A_j (restore).
  - S5: pulse done for 1 cycle, return to IDLE (ready=1 the cycle after done).
- Operation totals: 3*AWIDTH+2 writes, AWIDTH+AWIDTH^2 reads (AWIDTH=8: 26 writes, 72 reads).
- Fault handling: the test continues after a fault; done always pulses at the end.
- start while busy (ready=0) is ignored.
- clear has priority over start and over all in-flight state. A late m_rval after clear is ignored, with no fault.
- Async reset mid-operation gives the reset values immediately.

Optional Feature:
- Macro MMV_RAM_AB_TESTER_STOP_ON_FAULT_EN.
- Defined:
  - The first mismatch pulses fault and done on the same cycle.
  - The sequence then aborts to IDLE.
- Undefined: the full sequence always runs, with one fault pulse per mismatch, as specified above.

Test Plan:
1. Healthy memory model (latency 16, AWIDTH=DWIDTH=8), start pulse -> 26 writes and 72 reads issued; fault never pulses; exactly one done; ready returns to 1.
2. Alias fault: slave sees m_addr bit6 replaced by bit5 -> S2 read of 0x40 returns 0x55, fault pulses; done still pulses once.
3. m_busy held high for 5 cycles during a write and during a read -> m_addr, m_wdat and request held stable; no duplicate or lost operations (totals still 26/72).
4. Read latency 1 and latency 16 -> identical operation order and result.
5. clear asserted mid-S4 -> IDLE next cycle, ready=1, no done; a following start reruns from S1.
6. start re-pulsed while running, and async reset mid-test -> start ignored; reset forces ready=1 and all requests 0 immediately.
